pipelined_multiplier: RTL and testbench

Parametrised, pipelined successor to the single-cycle multiplier in the stc0 datapath. It takes operands A and B with a per-beat signed/unsigned mode and returns the full-width product after a configurable number of register stages, with a matching valid pipeline. An optional accumulator stage can be compiled in to turn the block into a multiply-accumulate unit for the downstream filter and compute stages.

---
 rtl/stc0_mult_pkg.sv | 19 +
 rtl/pipelined_multiplier_valid_delay_line.sv | 23 ++
 rtl/pipelined_multiplier.sv | 143 ++++++++++++++
 tb/tb_pipelined_multiplier.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stc0_mult_pkg.sv
// Shared widths, sideband bundle and helpers for the stc0 pipelined multiplier.
package stc0_mult_pkg;

  localparam int unsigned DEF_WIDTHA      = 17;
  localparam int unsigned DEF_WIDTHB      = 17;
  localparam int unsigned DEF_PIPE_STAGES = 2;
  localparam int unsigned DEF_ACC_WIDTH   = 40;

  typedef struct packed {
    logic is_signed;
    logic acc_en;
    logic acc_clr;
  } sideband_t;

  function automatic int unsigned prod_width(input int unsigned wa, input int unsigned wb);
    return wa + wb;
  endfunction

endpackage

// File: rtl/pipelined_multiplier_valid_delay_line.sv
// Resettable shift register of depth N and width W; every tap is exposed.
module valid_delay_line #(
  parameter int unsigned N = 1,
  parameter int unsigned W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          d,
  output logic [N-1:0][W-1:0]   taps
);

  always_ff @(posedge clk) begin
    if (rst) begin
      taps <= '0;
    end else begin
      taps[0] <= d;
      for (int unsigned i = 1; i < N; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/pipelined_multiplier.sv
// Pipelined signed/unsigned multiplier; defining MULT_ACC_EN adds an
// accumulator stage (Acc/AccOvf) and one cycle of latency.
module pipelined_multiplier
  import stc0_mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTHA = DEF_WIDTHA,
  parameter int unsigned DATA_WIDTHB = DEF_WIDTHB,
  parameter int unsigned PIPE_STAGES = DEF_PIPE_STAGES,
  parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH
) (
  input  logic                                           Clk,
  input  logic                                           ARst,
  input  logic [DATA_WIDTHA-1:0]                         A,
  input  logic [DATA_WIDTHB-1:0]                         B,
  input  logic                                           Signed,
  input  logic                                           ValidIn,
  input  logic                                           AccEn,
  input  logic                                           AccClr,
  output logic [prod_width(DATA_WIDTHA, DATA_WIDTHB)-1:0] P,
  output logic                                           ValidOut,
  output logic [ACC_WIDTH-1:0]                           Acc,
  output logic                                           AccOvf
);

  localparam int unsigned PW = prod_width(DATA_WIDTHA, DATA_WIDTHB);
  localparam int unsigned SW = $bits(sideband_t);

  if (PIPE_STAGES < 1) begin : g_bad_stages
    $error("PIPE_STAGES must be at least 1");
  end

  sideband_t                      sb_in;
  logic [PIPE_STAGES-1:0][SW:0]   taps;
  logic [PW-1:0]                  ext_a;
  logic [PW-1:0]                  ext_b;
  logic [PW-1:0]                  prod_now;
  logic [PIPE_STAGES-1:0][PW-1:0] prod_q;
  logic                           mult_valid;
  logic [PW-1:0]                  mult_p;
  logic                           unused_taps;

  always_comb begin
    sb_in.is_signed = Signed;
    sb_in.acc_en    = AccEn & ValidIn;
    sb_in.acc_clr   = AccClr & ValidIn;
  end

  // Valid bit rides at the MSB of each tap, sideband below it.
  valid_delay_line #(
    .N (PIPE_STAGES),
    .W (SW + 1)
  ) u_delay (
    .clk  (Clk),
    .rst  (ARst),
    .d    ({ValidIn, sb_in}),
    .taps (taps)
  );

  // Low PW bits of the extended product are exact for both modes.
  always_comb begin
    ext_a    = Signed ? {{DATA_WIDTHB{A[DATA_WIDTHA-1]}}, A} : {{DATA_WIDTHB{1'b0}}, A};
    ext_b    = Signed ? {{DATA_WIDTHA{B[DATA_WIDTHB-1]}}, B} : {{DATA_WIDTHA{1'b0}}, B};
    prod_now = ext_a * ext_b;
  end

  always_ff @(posedge Clk) begin
    if (ARst) begin
      prod_q <= '0;
    end else begin
      if (ValidIn) begin
        prod_q[0] <= prod_now;
      end
      for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
        if (taps[k-1][SW]) begin
          prod_q[k] <= prod_q[k-1];
        end
      end
    end
  end

  assign mult_valid  = taps[PIPE_STAGES-1][SW];
  assign mult_p      = prod_q[PIPE_STAGES-1];
  assign unused_taps = ^taps;

`ifdef MULT_ACC_EN
  if (ACC_WIDTH < PW) begin : g_bad_acc
    $error("ACC_WIDTH must be at least DATA_WIDTHA+DATA_WIDTHB");
  end

  sideband_t            mult_sb;
  logic [ACC_WIDTH-1:0] ext_p;
  logic [ACC_WIDTH:0]   sum;
  logic                 add_ovf;
  logic [PW-1:0]        p_q;
  logic                 valid_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;

  always_comb begin
    mult_sb = sideband_t'(taps[PIPE_STAGES-1][SW-1:0]);
    ext_p   = mult_sb.is_signed ? ACC_WIDTH'($signed(mult_p)) : ACC_WIDTH'(mult_p);
    sum     = {1'b0, acc_q} + {1'b0, ext_p};
    add_ovf = mult_sb.is_signed
              ? ((acc_q[ACC_WIDTH-1] == ext_p[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
              : sum[ACC_WIDTH];
  end

  always_ff @(posedge Clk) begin
    if (ARst) begin
      valid_q <= 1'b0;
      p_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= mult_valid;
      if (mult_valid) begin
        p_q <= mult_p;
        if (mult_sb.acc_clr) begin
          acc_q <= ext_p;
          ovf_q <= 1'b0;
        end else if (mult_sb.acc_en) begin
          acc_q <= sum[ACC_WIDTH-1:0];
          ovf_q <= ovf_q | add_ovf;
        end else begin
          acc_q <= ext_p;
        end
      end
    end
  end

  assign P        = p_q;
  assign ValidOut = valid_q;
  assign Acc      = acc_q;
  assign AccOvf   = ovf_q;
`else
  assign P        = mult_p;
  assign ValidOut = mult_valid;
  assign Acc      = '0;
  assign AccOvf   = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Self-checking bench for pipelined_multiplier against a cycle-keyed scoreboard.
module tb_pipelined_multiplier;

  localparam int unsigned WA = 17;
  localparam int unsigned WB = 17;
  localparam int unsigned PS = 2;
  localparam int unsigned AW = 40;
  localparam int unsigned PW = WA + WB;
`ifdef MULT_ACC_EN
  localparam int LAT = PS + 1;
`else
  localparam int LAT = PS;
`endif

  logic          Clk = 1'b0;
  logic          ARst = 1'b1;
  logic [WA-1:0] A = '0;
  logic [WB-1:0] B = '0;
  logic          Signed = 1'b0;
  logic          ValidIn = 1'b0;
  logic          AccEn = 1'b0;
  logic          AccClr = 1'b0;
  logic [PW-1:0] P;
  logic          ValidOut;
  logic [AW-1:0] Acc;
  logic          AccOvf;

  pipelined_multiplier #(
    .DATA_WIDTHA (WA),
    .DATA_WIDTHB (WB),
    .PIPE_STAGES (PS),
    .ACC_WIDTH   (AW)
  ) dut (
    .Clk (Clk), .ARst (ARst), .A (A), .B (B), .Signed (Signed),
    .ValidIn (ValidIn), .AccEn (AccEn), .AccClr (AccClr),
    .P (P), .ValidOut (ValidOut), .Acc (Acc), .AccOvf (AccOvf)
  );

`ifdef MULT_ACC_EN
  logic [PW-1:0] p2;
  logic          v2;
  logic [PW-1:0] acc2;
  logic          ovf2;

  pipelined_multiplier #(
    .DATA_WIDTHA (WA),
    .DATA_WIDTHB (WB),
    .PIPE_STAGES (PS),
    .ACC_WIDTH   (PW)
  ) dut_narrow (
    .Clk (Clk), .ARst (ARst), .A (A), .B (B), .Signed (Signed),
    .ValidIn (ValidIn), .AccEn (AccEn), .AccClr (AccClr),
    .P (p2), .ValidOut (v2), .Acc (acc2), .AccOvf (ovf2)
  );
`endif

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Expected outputs keyed by the cycle in which they must appear.
  logic [PW-1:0] sch_p   [int];
  bit            sch_s   [int];
  bit            sch_en  [int];
  bit            sch_clr [int];

  logic          e_valid = 1'b0;
  logic [PW-1:0] e_p = '0;
  logic [63:0]   e_acc = '0;
  logic          e_ovf = 1'b0;

  function automatic logic [PW-1:0] ref_product(logic [WA-1:0] a, logic [WB-1:0] b, bit s);
    longint x = longint'(a);
    longint y = longint'(b);
    longint r;
    if (s && a[WA-1]) x = x - (longint'(1) << WA);
    if (s && b[WB-1]) y = y - (longint'(1) << WB);
    r = x * y;
    return r[PW-1:0];
  endfunction

`ifdef MULT_ACC_EN
  task automatic model_emerge(logic [PW-1:0] p, bit s, bit en, bit clr);
    logic [63:0] m = (64'd1 << AW) - 1;
    longint ext = longint'({30'd0, p});
    longint acc_s;
    longint sum;
    longint lim = longint'(1) << (AW - 1);
    if (s && p[PW-1]) ext = ext - (longint'(1) << PW);
    if (clr) begin
      e_acc = ext & m;
      e_ovf = 1'b0;
    end else if (en) begin
      if (s) begin
        acc_s = longint'(e_acc);
        if (e_acc[AW-1]) acc_s = acc_s - (longint'(1) << AW);
        sum = acc_s + ext;
        if (sum >= lim || sum < -lim) e_ovf = 1'b1;
      end else if (e_acc + {30'd0, p} >= (64'd1 << AW)) begin
        e_ovf = 1'b1;
      end
      e_acc = (e_acc + ext) & m;
    end else begin
      e_acc = ext & m;
    end
  endtask
`endif

  task automatic step();
    bit cap = ValidIn && !ARst;
    bit rst = ARst;
    if (cap) begin
      sch_p[cyc + LAT]   = ref_product(A, B, Signed);
      sch_s[cyc + LAT]   = Signed;
      sch_en[cyc + LAT]  = AccEn;
      sch_clr[cyc + LAT] = AccClr;
    end
    @(posedge Clk);
    #1;
    cyc++;
    if (rst) begin
      sch_p.delete(); sch_s.delete(); sch_en.delete(); sch_clr.delete();
      e_valid = 1'b0; e_p = '0; e_acc = '0; e_ovf = 1'b0;
    end else if (sch_p.exists(cyc)) begin
      e_valid = 1'b1;
      e_p     = sch_p[cyc];
`ifdef MULT_ACC_EN
      model_emerge(sch_p[cyc], sch_s[cyc], sch_en[cyc], sch_clr[cyc]);
`endif
      sch_p.delete(cyc); sch_s.delete(cyc); sch_en.delete(cyc); sch_clr.delete(cyc);
    end else begin
      e_valid = 1'b0;
    end
  endtask

  task automatic beat(logic [WA-1:0] a, logic [WB-1:0] b, bit s, bit en, bit clr);
    A = a; B = b; Signed = s; AccEn = en; AccClr = clr; ValidIn = 1'b1;
  endtask

  task automatic test_reset();
    ARst = 1'b1; ValidIn = 1'b0;
    step(); step();
    ARst = 1'b0;
    vectors++; if (ValidOut !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", ValidOut); end
    vectors++; if (P !== '0) begin miscompares++; $display("FAIL reset_p: got %h want 0", P); end
    vectors++; if (Acc !== '0) begin miscompares++; $display("FAIL reset_acc: got %h want 0", Acc); end
    vectors++; if (AccOvf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", AccOvf); end
  endtask

  task automatic test_unsigned_max();
    int k = 1;
    beat(17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0, 1'b1);
    step();
    ValidIn = 1'b0;
    while (ValidOut !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    vectors++; if (k !== LAT) begin miscompares++; $display("FAIL umax_latency: got %0d want %0d", k, LAT); end
    vectors++; if (P !== 34'h3FFFC0001) begin miscompares++; $display("FAIL umax_p: got %h want 3fffc0001", P); end
    step();
    vectors++; if (ValidOut !== 1'b0) begin miscompares++; $display("FAIL umax_single: got %b want 0", ValidOut); end
  endtask

  task automatic test_signed_extremes();
    logic [PW-1:0] want [2] = '{34'h100000000, 34'h3FFFFFFFD};
    int idx = 0;
    beat(17'h10000, 17'h10000, 1'b1, 1'b0, 1'b1);
    step();
    beat(17'h1FFFF, 17'h00003, 1'b1, 1'b0, 1'b1);
    step();
    ValidIn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ValidOut === 1'b1 && idx < 2) begin
        vectors++; if (P !== want[idx]) begin miscompares++; $display("FAIL signed_p%0d: got %h want %h", idx, P, want[idx]); end
        idx++;
      end
      step();
    end
    vectors++; if (idx !== 2) begin miscompares++; $display("FAIL signed_count: got %0d want 2", idx); end
  endtask

  task automatic test_streaming();
    int run = 0;
    int best = 0;
    logic [11:0] pat = 12'b1100_1011_1000;
    for (int i = 0; i < 16 + 12 + 2 * LAT + 4; i++) begin
      if (i < 16) begin
        beat(WA'($urandom), WB'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0));
      end else if (i >= 16 + LAT + 2 && i < 16 + LAT + 14) begin
        beat(WA'($urandom), WB'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0));
        ValidIn = pat[11 - (i - 16 - LAT - 2)];
      end else begin
        ValidIn = 1'b0;
      end
      step();
      vectors++; if (ValidOut !== e_valid) begin miscompares++; $display("FAIL stream_valid c%0d: got %b want %b", cyc, ValidOut, e_valid); end
      vectors++; if (P !== e_p) begin miscompares++; $display("FAIL stream_p c%0d: got %h want %h", cyc, P, e_p); end
      vectors++; if (Acc !== e_acc[AW-1:0]) begin miscompares++; $display("FAIL stream_acc c%0d: got %h want %h", cyc, Acc, e_acc[AW-1:0]); end
      vectors++; if (AccOvf !== e_ovf) begin miscompares++; $display("FAIL stream_ovf c%0d: got %b want %b", cyc, AccOvf, e_ovf); end
      if (i < 16 + LAT + 2) begin
        if (ValidOut === 1'b1) begin
          run++;
          if (run > best) best = run;
        end else begin
          run = 0;
        end
      end
    end
    vectors++; if (best !== 16) begin miscompares++; $display("FAIL stream_run: got %0d want 16", best); end
  endtask

`ifdef MULT_ACC_EN
  task automatic test_accumulate();
    logic [AW-1:0] want [4] = '{40'd12, 40'd42, 40'd46, 40'd49};
    int idx = 0;
    beat(17'd3, 17'd4, 1'b0, 1'b0, 1'b1); step();
    beat(17'd5, 17'd6, 1'b0, 1'b1, 1'b0); step();
    beat(17'd2, 17'd2, 1'b0, 1'b1, 1'b0); step();
    beat(17'd7, 17'd7, 1'b0, 1'b0, 1'b0); step();
    ValidIn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ValidOut === 1'b1 && idx < 4) begin
        vectors++; if (Acc !== want[idx]) begin miscompares++; $display("FAIL accum_acc%0d: got %0d want %0d", idx, Acc, want[idx]); end
        vectors++; if (AccOvf !== 1'b0) begin miscompares++; $display("FAIL accum_ovf%0d: got %b want 0", idx, AccOvf); end
        idx++;
      end
      step();
    end
    vectors++; if (idx !== 4) begin miscompares++; $display("FAIL accum_count: got %0d want 4", idx); end
  endtask

  task automatic test_overflow();
    logic [PW-1:0] want_acc [4] = '{34'h3FFFC0001, 34'h3FFF80002, 34'h1, 34'h6};
    logic          want_ovf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int idx = 0;
    beat(17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0, 1'b1); step();
    beat(17'h1FFFF, 17'h1FFFF, 1'b0, 1'b1, 1'b0); step();
    beat(17'd1, 17'd1, 1'b0, 1'b0, 1'b0); step();
    beat(17'd2, 17'd3, 1'b0, 1'b0, 1'b1); step();
    ValidIn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (v2 === 1'b1 && idx < 4) begin
        vectors++; if (acc2 !== want_acc[idx]) begin miscompares++; $display("FAIL ovf_acc%0d: got %h want %h", idx, acc2, want_acc[idx]); end
        vectors++; if (ovf2 !== want_ovf[idx]) begin miscompares++; $display("FAIL ovf_flag%0d: got %b want %b", idx, ovf2, want_ovf[idx]); end
        idx++;
      end
      step();
    end
    vectors++; if (idx !== 4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", idx); end
  endtask
`endif

  task automatic test_reset_midflight();
    for (int i = 0; i < LAT - 1; i++) begin
      beat(WA'($urandom), WB'($urandom), 1'($urandom), 1'b1, 1'b0);
      step();
    end
    beat(WA'($urandom), WB'($urandom), 1'($urandom), 1'b1, 1'b0);
    ARst = 1'b1;
    step();
    ARst = 1'b0;
    ValidIn = 1'b0;
    vectors++; if (P !== '0) begin miscompares++; $display("FAIL midrst_p: got %h want 0", P); end
    vectors++; if (Acc !== '0) begin miscompares++; $display("FAIL midrst_acc: got %h want 0", Acc); end
    vectors++; if (AccOvf !== 1'b0) begin miscompares++; $display("FAIL midrst_ovf: got %b want 0", AccOvf); end
    for (int i = 0; i < LAT + 4; i++) begin
      vectors++; if (ValidOut !== 1'b0) begin miscompares++; $display("FAIL midrst_valid c%0d: got %b want 0", cyc, ValidOut); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_extremes();
    test_streaming();
`ifdef MULT_ACC_EN
    test_accumulate();
    test_overflow();
`endif
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
